// File: rtl/mips_defs.sv
// Shared MIPS encoding constants: opcodes, R-type functs, op_sel codes, field positions.
// Pure definitions, no logic; also imported by the control decoder.
// No flow control here; consumers decide handshaking.
package mips_defs;

  // Bit position of the least significant bit of each instruction field.
  localparam int unsigned OPC_LSB   = 26;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_LSB = 6;

  // Primary opcodes.
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0a;
  localparam logic [5:0] OPC_SLTIU = 6'h0b;
  localparam logic [5:0] OPC_ANDI  = 6'h0c;
  localparam logic [5:0] OPC_LUI   = 6'h0f;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2b;

  // R-type function codes.
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  // Symbolic instruction select presented by the loader; 26..31 are illegal.
  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_ADDU = 5'd1,  OP_SUB   = 5'd2,  OP_SUBU  = 5'd3,
    OP_AND  = 5'd4,  OP_OR   = 5'd5,  OP_XOR   = 5'd6,  OP_NOR   = 5'd7,
    OP_SLT  = 5'd8,  OP_SLTU = 5'd9,  OP_SLL   = 5'd10, OP_SRL   = 5'd11,
    OP_SRA  = 5'd12, OP_JR   = 5'd13, OP_JALR  = 5'd14, OP_LW    = 5'd15,
    OP_SW   = 5'd16, OP_LUI  = 5'd17, OP_ADDI  = 5'd18, OP_ADDIU = 5'd19,
    OP_ANDI = 5'd20, OP_SLTI = 5'd21, OP_SLTIU = 5'd22, OP_BEQ   = 5'd23,
    OP_J    = 5'd24, OP_JAL  = 5'd25
  } op_sel_e;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_e;

  typedef enum logic {ST_IDLE, ST_WRITE} enc_state_e;

  // Place a right-aligned field value at bit position lsb of a 32-bit word.
  function automatic logic [31:0] put_field(input logic [25:0] val, input int unsigned lsb);
    return {6'b0, val} << lsb;
  endfunction

endpackage

// File: rtl/instr_encode_core.sv
// Combinational MIPS encoder: op_sel + symbolic fields -> 32-bit word and legal flag.
// Latency: zero cycles (pure combinational).
// No backpressure; the caller registers the result.
// Ports: op_sel/rs/rt/rd/shamt/imm16/target26 in; word (0 when illegal), legal out.
module instr_encode_core
  import mips_defs::*;
(
  input  logic [4:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  output logic [31:0] word,
  output logic        legal
);

  fmt_e       fmt;
  logic [5:0] opc;
  logic [5:0] funct;
  logic [4:0] rs_f, rt_f, rd_f, sh_f;

  // Select format/opcode/funct and force fields the instruction does not use.
  always_comb begin
    fmt   = FMT_R;
    opc   = OPC_RTYPE;
    funct = FN_SLL;
    rs_f  = rs;
    rt_f  = rt;
    rd_f  = rd;
    sh_f  = '0;       // only the shifts carry a shift amount
    legal = 1'b1;
    case (op_sel)
      OP_ADD:   funct = FN_ADD;
      OP_ADDU:  funct = FN_ADDU;
      OP_SUB:   funct = FN_SUB;
      OP_SUBU:  funct = FN_SUBU;
      OP_AND:   funct = FN_AND;
      OP_OR:    funct = FN_OR;
      OP_XOR:   funct = FN_XOR;
      OP_NOR:   funct = FN_NOR;
      OP_SLT:   funct = FN_SLT;
      OP_SLTU:  funct = FN_SLTU;
      OP_SLL:   begin funct = FN_SLL; rs_f = '0; sh_f = shamt; end
      OP_SRL:   begin funct = FN_SRL; rs_f = '0; sh_f = shamt; end
      OP_SRA:   begin funct = FN_SRA; rs_f = '0; sh_f = shamt; end
      OP_JR:    begin funct = FN_JR;   rt_f = '0; rd_f = '0; end
      OP_JALR:  begin funct = FN_JALR; rt_f = '0; end
      OP_LW:    begin fmt = FMT_I; opc = OPC_LW;    end
      OP_SW:    begin fmt = FMT_I; opc = OPC_SW;    end
      OP_LUI:   begin fmt = FMT_I; opc = OPC_LUI; rs_f = '0; end
      OP_ADDI:  begin fmt = FMT_I; opc = OPC_ADDI;  end
      OP_ADDIU: begin fmt = FMT_I; opc = OPC_ADDIU; end
      OP_ANDI:  begin fmt = FMT_I; opc = OPC_ANDI;  end
      OP_SLTI:  begin fmt = FMT_I; opc = OPC_SLTI;  end
      OP_SLTIU: begin fmt = FMT_I; opc = OPC_SLTIU; end
      OP_BEQ:   begin fmt = FMT_I; opc = OPC_BEQ;   end
      OP_J:     begin fmt = FMT_J; opc = OPC_J;     end
      OP_JAL:   begin fmt = FMT_J; opc = OPC_JAL;   end
      default:  legal = 1'b0;
    endcase
  end

  always_comb begin
    word = '0;
    if (legal) begin
      case (fmt)
        FMT_R: word = put_field(26'(rs_f), RS_LSB) | put_field(26'(rt_f), RT_LSB)
                    | put_field(26'(rd_f), RD_LSB) | put_field(26'(sh_f), SHAMT_LSB)
                    | put_field(26'(funct), 0);
        FMT_I: word = put_field(26'(opc), OPC_LSB) | put_field(26'(rs_f), RS_LSB)
                    | put_field(26'(rt_f), RT_LSB) | put_field(26'(imm16), 0);
        default: word = put_field(26'(opc), OPC_LSB) | put_field(target26, 0);
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes symbolic MIPS instructions and streams them into instruction memory.
// Latency: handshake at edge N -> mem_we from N+1; at most one word per 2 cycles.
// Backpressure: in_ready low while writing, while full, during clear and in reset.
// Ports: clk/rst_n; clear; in_valid/in_ready + op_sel/rs/rt/rd/shamt/imm16/target26;
//        mem_we/mem_addr/mem_wdata/mem_ack; word_count, full, err (sticky illegal op).
module instr_encoder
  import mips_defs::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256   // must not exceed 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm16,
  input  logic [25:0]       target26,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err
);

  localparam int              CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  enc_state_e       state_q, state_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             err_q, err_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept;

  instr_encode_core u_core (
    .op_sel   (op_sel),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .shamt    (shamt),
    .imm16    (imm16),
    .target26 (target26),
    .word     (enc_word),
    .legal    (enc_legal)
  );

  // Clear takes priority over a request in the same cycle, so it masks ready.
  // rst_n gates ready so nothing is offered while reset is held.
  assign in_ready = rst_n && (state_q == ST_IDLE) && !full_q && !clear;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    mem_we_d = mem_we_q;
    wdata_d  = wdata_q;
    count_d  = count_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          count_d = '0;
          err_d   = 1'b0;
        end else if (accept) begin
          if (enc_legal) begin
            wdata_d  = enc_word;
            mem_we_d = 1'b1;
            state_d  = ST_WRITE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        // Address and data stay frozen until memory takes the word.
        if (mem_ack) begin
          count_d  = count_q + ONE_C;
          mem_we_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    full_d = (count_d == DEPTH_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mem_we_q <= 1'b0;
      wdata_q  <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_we_q <= mem_we_d;
      wdata_q  <= wdata_d;
      count_q  <= count_d;
      full_q   <= full_d;
      err_q    <= err_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = count_q[ADDR_W-1:0];
  assign mem_wdata  = wdata_q;
  assign word_count = count_q;
  assign full       = full_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, mem_ack = 1'b0;
  logic [4:0]  op_sel = '0, rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [15:0] imm16 = '0;
  logic [25:0] target26 = '0;
  logic              in_ready, mem_we, full, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   word_count;

  int vectors = 0, miscompares = 0;
  int ack_wait = 0, we_cycles = 0;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm16(imm16),
    .target26(target26), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .word_count(word_count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired waiting for DUT at %0t", name, $time);
  endtask

  // Reference encoder built from the opcode/funct tables and field-forcing rules.
  function automatic logic [31:0] ref_encode(input int op, input logic [4:0] i_rs, i_rt,
      i_rd, i_sh, input logic [15:0] i_imm, input logic [25:0] i_tgt);
    int fn_tab [15] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27,
                        'h2a, 'h2b, 'h00, 'h02, 'h03, 'h08, 'h09};
    int i_tab  [9]  = '{'h23, 'h2b, 'h0f, 'h08, 'h09, 'h0c, 'h0a, 'h0b, 'h04};
    longint s = i_rs, t = i_rt, d = i_rd, h = i_sh, w;
    if (op < 15) begin
      if (op >= 10 && op <= 12) s = 0; else h = 0;
      if (op == 13) begin t = 0; d = 0; end
      if (op == 14) t = 0;
      w = s * 2**21 + t * 2**16 + d * 2**11 + h * 64 + fn_tab[op];
    end else if (op < 24) begin
      if (op == 17) s = 0;
      w = longint'(i_tab[op-15]) * 2**26 + s * 2**21 + t * 2**16 + longint'(i_imm);
    end else begin
      w = longint'(op - 22) * 2**26 + longint'(i_tgt);
    end
    return 32'(w);
  endfunction

  // Transaction-level model of the encoder/writer.
  bit          m_busy = 0, m_err = 0;
  int          m_count = 0;
  logic [31:0] m_word = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_count <= 0; m_err <= 0; m_word <= '0;
    end else if (m_busy) begin
      if (mem_ack) begin m_busy <= 0; m_count <= m_count + 1; end
    end else if (clear) begin
      m_count <= 0; m_err <= 0;
    end else if (in_valid && m_count != DEPTH) begin
      if (op_sel <= 5'd25) begin
        m_busy <= 1;
        m_word <= ref_encode(int'(op_sel), rs, rt, rd, shamt, imm16, target26);
      end else begin
        m_err <= 1;
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready",   32'(in_ready),   32'(rst_n && !m_busy && m_count != DEPTH && !clear));
    check("mem_we",     32'(mem_we),     32'(m_busy));
    check("mem_addr",   32'(mem_addr),   32'(m_count % (1 << ADDR_W)));
    check("mem_wdata",  mem_wdata,       m_word);
    check("word_count", 32'(word_count), 32'(m_count));
    check("full",       32'(full),       32'(m_count == DEPTH));
    check("err",        32'(err),        32'(m_err));
  end

  // Memory model: acknowledges after ack_wait cycles of mem_we.
  always @(negedge clk) begin
    if (mem_we) begin
      mem_ack   <= (we_cycles == ack_wait);
      we_cycles <= we_cycles + 1;
    end else begin
      mem_ack   <= 1'b0;
      we_cycles <= 0;
    end
  end

  task automatic send(input logic [4:0] op, input logic [4:0] s, t, d, h,
                      input logic [15:0] im, input logic [25:0] tg);
    bit done = 0;
    @(posedge clk); #1;
    op_sel = op; rs = s; rt = t; rd = d; shamt = h; imm16 = im; target26 = tg;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
    end
    if (!done) timeout("send_handshake");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!mem_we) done = 1;
    end
    if (!done) timeout("write_complete");
  endtask

  task automatic do_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_in_ready",   32'(in_ready),   0);
    check("rst_mem_we",     32'(mem_we),     0);
    check("rst_mem_addr",   32'(mem_addr),   0);
    check("rst_mem_wdata",  mem_wdata,       0);
    check("rst_word_count", 32'(word_count), 0);
    check("rst_full",       32'(full),       0);
    check("rst_err",        32'(err),        0);
    @(posedge clk); #1 rst_n = 1'b1;

    // add with nonzero shamt: shamt forced to 0
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd9, 16'h0, 26'h0);
    @(negedge clk);
    check("add_we",   32'(mem_we),   1);
    check("add_addr", 32'(mem_addr), 0);
    check("add_word", mem_wdata,     32'h00221820);
    wait_idle();
    check("add_count", 32'(word_count), 1);

    do_clear();
    send(5'd15, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0);
    @(negedge clk);
    check("lw_addr", 32'(mem_addr), 0);
    check("lw_word", mem_wdata,     32'h8FA80004);
    wait_idle();
    send(5'd25, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000);
    @(negedge clk);
    check("jal_addr", 32'(mem_addr), 1);
    check("jal_word", mem_wdata,     32'h0C100000);
    wait_idle();

    // clear together with a request: clear wins
    @(posedge clk); #1;
    clear = 1'b1; in_valid = 1'b1; op_sel = 5'd0;
    @(negedge clk);
    check("clr_wins_ready", 32'(in_ready), 0);
    @(posedge clk); #1 clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("clr_wins_we",    32'(mem_we),     0);
    check("clr_wins_count", 32'(word_count), 0);

    send(5'd10, 5'd5, 5'd3, 5'd2, 5'd4, 16'hFFFF, 26'h0);
    @(negedge clk);
    check("sll_word", mem_wdata, 32'h00031100);
    wait_idle();
    send(5'd17, 5'd7, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0);
    @(negedge clk);
    check("lui_addr", 32'(mem_addr), 1);
    check("lui_word", mem_wdata,     32'h3C011234);
    wait_idle();
    do_clear();

    // stalled ack; a clear during the write must be ignored
    ack_wait = 3;
    send(5'd4, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    clear = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!mem_we) break;
      n++;
      check("stall_addr",  32'(mem_addr), 0);
      check("stall_word",  mem_wdata,     32'h00221824);
      check("stall_ready", 32'(in_ready), 0);
      if (i == 1) clear = 1'b0;
    end
    clear = 1'b0;
    check("stall_cycles", 32'(n), 4);
    check("stall_count",  32'(word_count), 1);
    ack_wait = 0;

    // fill to DEPTH
    send(5'd5, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);  wait_idle();
    send(5'd6, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);  wait_idle();
    send(5'd7, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);  wait_idle();
    check("full_count", 32'(word_count), 4);
    check("full_flag",  32'(full),       1);
    check("full_ready", 32'(in_ready),   0);
    @(posedge clk); #1 in_valid = 1'b1; op_sel = 5'd0;
    repeat (4) begin
      @(negedge clk);
      check("full_no_write", 32'(mem_we), 0);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    check("full_count_hold", 32'(word_count), 4);
    do_clear();
    @(negedge clk);
    check("clr_count", 32'(word_count), 0);
    check("clr_full",  32'(full),       0);
    check("clr_ready", 32'(in_ready),   1);
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    @(negedge clk);
    check("after_clr_addr", 32'(mem_addr), 0);
    wait_idle();

    // illegal op_sel
    send(5'd30, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
    @(negedge clk);
    check("illegal_err", 32'(err), 1);
    repeat (3) begin
      @(negedge clk);
      check("illegal_no_we", 32'(mem_we), 0);
    end
    check("illegal_count", 32'(word_count), 1);
    send(5'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    @(negedge clk);
    check("sub_word",   mem_wdata,     32'h00221822);
    check("err_sticky", 32'(err),      1);
    wait_idle();

    // reset in the middle of a stalled write
    ack_wait = 10;
    send(5'd24, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF);
    @(negedge clk);
    check("j_word", mem_wdata, 32'h0BFFFFFF);
    #2 rst_n = 1'b0;
    #1;
    check("arst_we",    32'(mem_we),     0);
    check("arst_addr",  32'(mem_addr),   0);
    check("arst_wdata", mem_wdata,       0);
    check("arst_count", 32'(word_count), 0);
    check("arst_err",   32'(err),        0);
    check("arst_ready", 32'(in_ready),   0);
    @(posedge clk); #1 rst_n = 1'b1;
    ack_wait = 0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
